uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte stream among NUM_REQ requesters (e.g. loopback echo, status reporter, debug console).
- Sits between the requesters and the UART TX valid/ready byte interface inside the FPGA top-level wrappers.
- Grants are round-robin and held per message: a grant persists until the requester's last byte or a burst limit, so messages are never interleaved mid-burst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width of each stream.
- MAX_BURST, 16, max bytes per grant before forced release (starvation guard); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte is the final byte of the message.
- req_ready  out  NUM_REQ  per-requester accept.
- tx_valid  out  1  byte valid to UART TX.
- tx_data  out  DATA_WIDTH  byte to UART TX.
- tx_ready  in  1  UART TX accepts the byte.
- grant_id  out  clog2(NUM_REQ)  currently or last granted requester.
- busy  out  1  a grant is active.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is asynchronous, active-low (rst_n); all flops clear on assertion.
- Reset values:
  - state = IDLE; grant_id = 0; last_grant = NUM_REQ-1, so requester 0 wins first.
  - burst_cnt = 0.
  - Outputs: tx_valid = 0, tx_data = 0, req_ready = 0, busy = 0.
- FSM has 2 states, IDLE and GRANT.
- IDLE:
  - tx_valid = 0, req_ready = 0.
  - If any req_valid is set, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - Register the pick into grant_id, clear burst_cnt, go to GRANT.
  - Arbitration latency is 1 cycle: the earliest transfer is the cycle after the request is seen in IDLE.
- GRANT (g = grant_id), combinational mux:
  - tx_valid = req_valid[g]; tx_data = req_data[g].
  - req_ready[g] = tx_ready; all other req_ready = 0.
  - busy = 1.
- Transfer: the cycle where tx_valid && tx_ready.
  - Each transfer increments burst_cnt.
  - burst_cnt width is clog2(MAX_BURST+1); it never wraps.
- Release, on a transfer cycle only:
  - Release if req_last[g] = 1, or if burst_cnt+1 == MAX_BURST.
  - On release: last_grant <= g, go to IDLE.
  - There is at least 1 idle cycle between grants.
  - grant_id holds its value through IDLE.
- Requester deasserts req_valid while granted: the grant is held (tx_valid = 0) until it resumes. There is no timeout.
- Other requesters' valid/data are ignored while not granted. They must hold valid and data stable until ready, per the valid/ready rule.
- tx_ready low: nothing is transferred, burst_cnt is unchanged, the grant is held.
- req_last on a non-transfer cycle has no effect.
- Reset mid-message: the grant is dropped immediately.
  - The UART byte currently in flight is the TX block's concern.
  - After release the arbiter restarts from requester 0 priority.
- Single requester continuously valid: it is re-granted after each release with a 1-cycle gap.
- Throughput: up to 1 byte/cycle while granted, limited by tx_ready.

Test Plan:
- Reset, then req_valid = 4'b0000 for 10 cycles -> busy = 0, tx_valid = 0, req_ready = 0, grant_id = 0.
- Requesters 1 and 3 both valid, 3-byte messages (0x41,0x42,0x43 last / 0x61,0x62,0x63 last), tx_ready = 1 -> tx_data sequence 41,42,43, 1 idle cycle, 61,62,63; grant_id 1 then 3.
- All 4 requesters hold 1-byte messages (last = 1) continuously -> grant order 0,1,2,3,0,1; each grant is 1 transfer plus 1 idle cycle.
- Requester 2 streams 20 bytes 0x00..0x13 with last only on 0x13, MAX_BURST = 16, requester 0 also valid:
  - After 0x0F the grant releases and passes to requester 0.
  - Requester 2 later resumes with 0x10..0x13.
- Granted requester 0, tx_ready toggles 1/0 each cycle over a 4-byte message -> exactly 4 transfers, no byte duplicated or dropped, req_ready[0] == tx_ready throughout.
- Assert rst_n low for 1 cycle mid-message of requester 2 -> outputs clear at once; next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte streams share one UART TX valid/ready port.
// Grants are held per message, or until MAX_BURST bytes have moved, and are followed by one idle cycle.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_q;
    logic [BW-1:0] burst_q;
    logic [GW-1:0] pick_d;
    logic [GW-1:0] scan_idx [NUM_REQ];
    logic          xfer;
    logic          rel;

    // scan_idx[k] is the requester checked k-th, starting just after the last grant
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
        assign scan_idx[k] = GW'((int'(last_q) + k + 1) % NUM_REQ);
    end

    always_comb begin
        pick_d = scan_idx[0];
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[scan_idx[k]]) begin
                pick_d = scan_idx[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        if (state_q == GRANT) begin
            tx_valid           = req_valid[grant_q];
            tx_data            = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
            req_ready[grant_q] = tx_ready;
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = grant_q;
    assign xfer     = tx_valid && tx_ready;
    assign rel      = xfer && (req_last[grant_q] || (burst_q + 1'b1 == BW'(MAX_BURST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q <= pick_d;
                        burst_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        burst_q <= burst_q + 1'b1;
                    end
                    if (rel) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a message-level arbitration model,
// directed scenarios and a randomized mix with valid gaps and random tx_ready.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] mem [N][64];
    int         hd [N];
    int         tl [N];
    bit         gap_mode;
    int         rdy_mode;

    // model: which requester owns the port, how many bytes it has moved, who went last
    bit m_busy;
    int m_owner;
    int m_prev;
    int m_cnt;

    logic [7:0] exp_s[$];
    logic [7:0] act_s[$];
    int         exp_g[$];
    int         act_g[$];
    bit         busy_prev;

    task automatic push(input int r, input logic [7:0] d, input bit l);
        mem[r][tl[r]] = {l, d};
        tl[r]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        exp_s.delete();
        act_s.delete();
        exp_g.delete();
        act_g.delete();
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_prev  = N - 1;
        m_cnt   = 0;
    endtask

    function automatic bit pending();
        bit p = m_busy;
        for (int i = 0; i < N; i++) if (hd[i] < tl[i]) p = 1'b1;
        return p;
    endfunction

    // one clock: drive at negedge, compare 1 time unit later, advance model at posedge
    task automatic cycle();
        logic [N-1:0] er;
        bit           ev;
        for (int i = 0; i < N; i++) begin
            bit en;
            en = !gap_mode || ($urandom_range(0, 3) != 0);
            req_valid[i] = (hd[i] < tl[i]) && en;
            req_data[i*DW +: DW] = (hd[i] < tl[i]) ? mem[i][hd[i]][7:0] : 8'h00;
            req_last[i] = (hd[i] < tl[i]) ? mem[i][hd[i]][8] : 1'b0;
        end
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = cyc[0];
            default: tx_ready = ($urandom_range(0, 1) == 1);
        endcase
        #1;
        ev = m_busy && req_valid[m_owner];
        er = '0;
        if (m_busy && tx_ready) er[2'(m_owner)] = 1'b1;
        checks += 4;
        if (busy !== m_busy) begin
            failures++;
            $display("FAIL cyc%0d busy: got %b want %b", cyc, busy, m_busy);
        end
        if (grant_id !== 2'(m_owner)) begin
            failures++;
            $display("FAIL cyc%0d grant_id: got %0d want %0d", cyc, grant_id, m_owner);
        end
        if (tx_valid !== ev) begin
            failures++;
            $display("FAIL cyc%0d tx_valid: got %b want %b", cyc, tx_valid, ev);
        end
        if (req_ready !== er) begin
            failures++;
            $display("FAIL cyc%0d req_ready: got %b want %b", cyc, req_ready, er);
        end
        if (ev) begin
            checks++;
            if (tx_data !== req_data[m_owner*DW +: DW]) begin
                failures++;
                $display("FAIL cyc%0d tx_data: got %h want %h", cyc, tx_data, req_data[m_owner*DW +: DW]);
            end
        end
        if (tx_valid === 1'b1 && tx_ready) act_s.push_back(tx_data);
        if (busy === 1'b1 && !busy_prev) act_g.push_back(int'(grant_id));
        busy_prev = (busy === 1'b1);
        @(posedge clk);
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_prev + k) % N;
                if (!m_busy && req_valid[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_cnt   = 0;
                    exp_g.push_back(c);
                end
            end
        end else if (req_valid[m_owner] && tx_ready) begin
            exp_s.push_back(req_data[m_owner*DW +: DW]);
            hd[m_owner]++;
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_prev = m_owner;
                m_busy = 1'b0;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_drained(input int maxc, input string name);
        int n = 0;
        while (pending() && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        if (pending()) begin
            failures++;
            $display("FAIL %s timeout: got %0d cycles, required drain within %0d", name, n, maxc);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        gap_mode  = 1'b0;
        rdy_mode  = 0;
        busy_prev = 1'b0;
        clear_all();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== '0 || grant_id !== 2'd0 || tx_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b vld=%b rdy=%b gid=%0d dat=%h, want all zero",
                     busy, tx_valid, req_ready, grant_id, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) cycle();
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== '0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b vld=%b rdy=%b gid=%0d, want 0/0/0/0",
                     busy, tx_valid, req_ready, grant_id);
        end
    endtask

    task automatic test_two_messages();
        logic [7:0] want[$];
        clear_all();
        rdy_mode = 0;
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
        push(3, 8'h61, 0); push(3, 8'h62, 0); push(3, 8'h63, 1);
        run_until_drained(40, "two_messages");
        want = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63};
        checks++;
        if (act_s != want) begin
            failures++;
            $display("FAIL two_messages_stream: got %p want %p", act_s, want);
        end
        checks++;
        if (act_g.size() != 2 || act_g[0] != 1 || act_g[1] != 3) begin
            failures++;
            $display("FAIL two_messages_grants: got %p want 1,3", act_g);
        end
    endtask

    task automatic test_round_robin();
        clear_all();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < N; r++) push(r, 8'(8'h10 * r + m), 1);
        run_until_drained(40, "round_robin");
        checks++;
        if (act_g.size() != 8) begin
            failures++;
            $display("FAIL round_robin_count: got %0d grants want 8", act_g.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (act_g[i] != i % N) begin
                    failures++;
                    $display("FAIL round_robin_order[%0d]: got %0d want %0d", i, act_g[i], i % N);
                end
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [7:0] want[$];
        clear_all();
        for (int b = 0; b < 20; b++) push(2, 8'(b), b == 19);
        repeat (2) cycle();
        push(0, 8'hA0, 0);
        push(0, 8'hA1, 1);
        run_until_drained(80, "burst_limit");
        want.delete();
        for (int b = 0; b < 16; b++) want.push_back(8'(b));
        want.push_back(8'hA0);
        want.push_back(8'hA1);
        for (int b = 16; b < 20; b++) want.push_back(8'(b));
        checks++;
        if (act_s != want) begin
            failures++;
            $display("FAIL burst_limit_stream: got %p want %p", act_s, want);
        end
        checks++;
        if (act_g.size() != 3 || act_g[0] != 2 || act_g[1] != 0 || act_g[2] != 2) begin
            failures++;
            $display("FAIL burst_limit_grants: got %p want 2,0,2", act_g);
        end
    endtask

    task automatic test_ready_toggle();
        logic [7:0] want[$];
        clear_all();
        rdy_mode = 1;
        push(0, 8'hC0, 0); push(0, 8'hC1, 0); push(0, 8'hC2, 0); push(0, 8'hC3, 1);
        run_until_drained(40, "ready_toggle");
        want = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        checks++;
        if (act_s.size() != 4) begin
            failures++;
            $display("FAIL ready_toggle_count: got %0d transfers want 4", act_s.size());
        end
        checks++;
        if (act_s != want) begin
            failures++;
            $display("FAIL ready_toggle_stream: got %p want %p", act_s, want);
        end
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid_message();
        logic [7:0] want[$];
        clear_all();
        for (int b = 0; b < 6; b++) push(2, 8'(8'hB0 + b), b == 5);
        repeat (4) cycle();
        push(1, 8'hD0, 1);
        push(3, 8'hE0, 1);
        cycle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || req_ready !== '0 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_clear: got busy=%b vld=%b rdy=%b gid=%0d, want 0/0/0/0",
                     busy, tx_valid, req_ready, grant_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        busy_prev = 1'b0;
        act_s.delete();
        exp_s.delete();
        act_g.delete();
        exp_g.delete();
        run_until_drained(40, "reset_mid");
        checks++;
        if (act_g.size() != 3 || act_g[0] != 1 || act_g[1] != 2 || act_g[2] != 3) begin
            failures++;
            $display("FAIL reset_mid_grants: got %p want 1,2,3", act_g);
        end
        want = '{8'hD0, 8'hB4, 8'hB5, 8'hE0};
        checks++;
        if (act_s != want) begin
            failures++;
            $display("FAIL reset_mid_stream: got %p want %p", act_s, want);
        end
    endtask

    task automatic test_random();
        gap_mode = 1'b1;
        rdy_mode = 2;
        for (int round = 0; round < 4; round++) begin
            clear_all();
            for (int r = 0; r < N; r++) begin
                int nmsg;
                nmsg = int'($urandom_range(0, 3));
                for (int m = 0; m < nmsg; m++) begin
                    int len;
                    len = int'($urandom_range(1, 18));
                    for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
                end
            end
            run_until_drained(3000, "random");
            checks++;
            if (act_s != exp_s) begin
                failures++;
                $display("FAIL random_stream round %0d: got %0d bytes want %0d", round, act_s.size(), exp_s.size());
            end
            checks++;
            if (act_g != exp_g) begin
                failures++;
                $display("FAIL random_grants round %0d: got %p want %p", round, act_g, exp_g);
            end
        end
        gap_mode = 1'b0;
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_two_messages();
        test_round_robin();
        test_burst_limit();
        test_ready_toggle();
        test_reset_mid_message();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
